digital_mem_responder: RTL
==========================

Name: digital_mem_responder

Overview:
- Synthesizable target-side RAM on the digital external memory interface: the responder that a digital-mode RAM bridge drives.
- Accepts read and write strobes, byte-size-coded writes, address and data.
- Returns data and a level `ready` after a programmable latency.
- Used as the on-FPGA and simulation stand-in for the Digital software memory, so the core can run without the external simulator.

Parameters:
- XLEN, `XLEN (32): data and address width, taken from config.v.
- DEPTH_WORDS, 4096: number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.
- LATENCY, 2: cycles from request capture to `ready`; must be ≥1.

Ports:
- ramclk  in  1  clock
- rst_n  in  1  reset
- digital_mem_addr  in  XLEN  byte address
- digital_mem_read_en  in  1  read request level
- digital_mem_write_en  in  1  write request level
- digital_mem_byte_size  in  4  size code
- digital_mem_wdata  in  XLEN  write data, low-byte packed
- digital_mem_data  out  XLEN  read data
- digital_mem_ready  out  1  request complete, level
- mem_err  out  1  one-cycle pulse on bad access
- rd_count  out  32  read statistics
- wr_count  out  32  write statistics

Interface: reset rst_n, asynchronous, active-low; clock ramclk.

Behaviour:
- Reset values:
  - State IDLE.
  - digital_mem_ready = 0, digital_mem_data = 0, mem_err = 0, rd_count = 0, wr_count = 0.
  - The memory array is not reset.
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - On an edge with read_en or write_en high, capture addr, wdata, byte_size and op, then go to BUSY.
  - Write has priority when both enables are high.
  - Latency counter loads LATENCY-1.
- BUSY:
  - Counter decrements each cycle.
  - When it reaches 0 (or immediately when LATENCY=1), perform the access and go to RESP; digital_mem_ready is registered to 1 on that same edge.
  - Ready therefore rises exactly LATENCY edges after the capture edge.
  - If both enables drop while in BUSY: abort, return to IDLE, no write committed, no counters incremented.
- RESP:
  - ready stays 1 and digital_mem_data stays stable while either enable is high.
  - On the first edge with both enables low: ready goes to 0 and the state returns to IDLE; data holds its last value.
  - A new request needs at least one IDLE cycle with both enables low; back-to-back level-high requests are not re-executed.
- Address decode:
  - offset = addr - BASE_ADDR.
  - Word index = offset[log2(DEPTH_WORDS)+1:2]; lane = offset[1:0].
  - Out of range is addr < BASE_ADDR or offset ≥ DEPTH_WORDS*4.
- Reads:
  - Always return the whole aligned word; byte_size is ignored (initiator sends 4'b1111) and lane is ignored.
  - Out of range: data = 0, mem_err pulses on the ready-rise edge, ready still asserts.
- Write size code (one-hot, bit = byte count - 1):
  - 4'b0001 = 1 byte.
  - 4'b0010 = 2 bytes.
  - 4'b1000 = 4 bytes.
  - 4'b1111 is also accepted as 4 bytes.
- Write lane mapping:
  - Bytes of wdata, starting at wdata[7:0], go to lanes lane, lane+1, and so on.
  - Lanes past 3 are dropped; there is no wrap into the next word.
  - A 4-byte write with lane≠0 writes only lanes lane..3.
- Bad writes:
  - Any other byte_size code, or an out-of-range address: no write, mem_err pulses, ready still asserts.
- Completed-access output:
  - A completed write also loads digital_mem_data with the post-write word (0 if out of range).
- Reset mid-operation: immediate return to IDLE with ready = 0; no partial write.
- Single-port array: one access per transaction; read-during-write hazards are impossible by construction.

Optional Feature:
- DIGITAL_MEM_STATS_EN defined:
  - rd_count and wr_count increment on each completed read or write (including error-flagged ones) at the ready-rise edge.
  - Both wrap modulo 2^32.
- Undefined: counter logic is not built and both ports are constant 0.

Test Plan:
- Full-word write then read: write addr 0x10, size 4'b1000, wdata 0xDEADBEEF, LATENCY=2 → ready rises 2 edges after capture. Then read 0x10 → data 0xDEADBEEF.
- Byte write on preloaded 0x11223344 at 0x20: addr 0x22, size 4'b0001, wdata 0x000000AA → read 0x20 returns 0x11AA3344.
- Halfword write at lane 3: addr 0x23, size 4'b0010, wdata 0x0000BBCC on word 0 → word = 0xCC000000; next word unchanged.
- Abort: drop read_en 1 cycle after capture with LATENCY=4 → ready never asserts, state IDLE. A following write to the same word commits normally.
- Out of range: read at BASE_ADDR+DEPTH_WORDS*4 → ready asserts, data 0, mem_err one-cycle pulse. Write size 4'b0100 → no change, mem_err pulse.
- Reset in BUSY during a write of 0x12345678 → ready = 0 and the word keeps its old value. With DIGITAL_MEM_STATS_EN, three completed reads and two completed writes → rd_count = 3, wr_count = 2.

Source files
------------

// File: rtl/digital_mem_responder.sv
// digital_mem_responder: latency-programmable RAM target for the digital external memory bus.
// Define DIGITAL_MEM_STATS_EN to build the rd_count/wr_count access counters.
module digital_mem_responder #(
  parameter int XLEN = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int LATENCY = 2
) (
  input  logic            ramclk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] digital_mem_addr,
  input  logic            digital_mem_read_en,
  input  logic            digital_mem_write_en,
  input  logic [3:0]      digital_mem_byte_size,
  input  logic [XLEN-1:0] digital_mem_wdata,
  output logic [XLEN-1:0] digital_mem_data,
  output logic            digital_mem_ready,
  output logic            mem_err,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, wdata_q, data_q, data_d;
  logic [3:0] size_q;
  logic wr_q, ready_q, ready_d, err_q, err_d;
  logic req, cap, access, oor, bad, do_wr;
  logic [XLEN-1:0] offset, cur, merged;
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic [2:0] nbytes;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  assign req    = digital_mem_read_en | digital_mem_write_en;
  assign offset = addr_q - BASE_ADDR;
  assign idx    = offset[AW+1:2];
  assign lane   = offset[1:0];
  assign oor    = (addr_q < BASE_ADDR) || (offset >= XLEN'(DEPTH_WORDS * 4));
  assign nbytes = (size_q == 4'b0001) ? 3'd1 :
                  (size_q == 4'b0010) ? 3'd2 :
                  (size_q == 4'b1000 || size_q == 4'b1111) ? 3'd4 : 3'd0;
  assign bad    = oor || (wr_q && nbytes == 3'd0);
  assign access = (state_q == BUSY) && req && (cnt_q == '0);
  assign do_wr  = access && wr_q && !bad;
  assign cur    = mem[idx];

  // Bytes past lane 3 fall off the word; no wrap into the next word.
  always_comb begin
    merged = cur;
    for (int l = 0; l < 4; l++)
      if (l >= int'(lane) && l - int'(lane) < int'(nbytes))
        merged[8*l +: 8] = wdata_q[8*(l - int'(lane)) +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    data_d  = data_q;
    err_d   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        cap     = 1'b1;
        cnt_d   = CW'(LATENCY - 1);
        state_d = BUSY;
      end
      BUSY: if (!req) state_d = IDLE;
      else if (cnt_q == '0) begin
        state_d = RESP;
        ready_d = 1'b1;
        err_d   = bad;
        data_d  = oor ? '0 : (wr_q ? merged : cur);
      end else cnt_d = cnt_q - CW'(1);
      RESP: if (!req) begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ramclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (cap) begin
        addr_q  <= digital_mem_addr;
        wdata_q <= digital_mem_wdata;
        size_q  <= digital_mem_byte_size;
        wr_q    <= digital_mem_write_en;
      end
    end
  end

  always_ff @(posedge ramclk)
    if (do_wr) mem[idx] <= merged;

  assign digital_mem_data  = data_q;
  assign digital_mem_ready = ready_q;
  assign mem_err           = err_q;

`ifdef DIGITAL_MEM_STATS_EN
  logic [31:0] rdc_q, wrc_q;
  always_ff @(posedge ramclk or negedge rst_n) begin
    if (!rst_n) begin
      rdc_q <= '0;
      wrc_q <= '0;
    end else if (access) begin
      if (wr_q) wrc_q <= wrc_q + 32'd1;
      else rdc_q <= rdc_q + 32'd1;
    end
  end
  assign rd_count = rdc_q;
  assign wr_count = wrc_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule
